// File: rtl/mfp_spi_slave_responder_if.sv
// Bundle for the SPI slave responder: SPI pins, local tx handshake and
// transfer status strobes.
interface mfp_spi_slave_responder_if #(
  parameter int WIDTH = 16
);
  logic             spi_cs_n;
  logic             spi_sck;
  logic             spi_sdo;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             busy;
  logic             done;
  logic             underrun;
  logic             aborted;

  modport master (
    output spi_cs_n, spi_sck, tx_data, tx_valid,
    input  spi_sdo, tx_ready, busy, done, underrun, aborted
  );

  modport slave (
    input  spi_cs_n, spi_sck, tx_data, tx_valid,
    output spi_sdo, tx_ready, busy, done, underrun, aborted
  );
endinterface

// File: rtl/mfp_spi_slave_responder.sv
// SPI mode-0 slave: shifts a buffered WIDTH-bit word MSB first onto MISO each
// time the master drops CS. CS and SCK are synchronized into clk.
//
// state | meaning
// IDLE  | waiting for CS fall, MISO held low
// SHIFT | CS low, presenting bits, counting SCK rises
module mfp_spi_slave_responder #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic                      clk,
  input logic                      rst,
  mfp_spi_slave_responder_if.slave bus
);

  localparam int              CW         = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   CNT_MAX    = CW'(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST   = CW'(WIDTH - 1);
  localparam int              FW         = $clog2(SYNC_STAGES + 2);
  localparam logic [FW-1:0]   FLUSH_LOAD = FW'(SYNC_STAGES + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic                   cs_hist;
  logic                   sck_hist;
  logic                   cs_s;
  logic                   sck_s;
  logic                   cs_fall;
  logic                   cs_rise;
  logic                   sck_rise;
  logic                   sck_fall;

  logic [FW-1:0]          flush_cnt;
  logic                   cs_armed;

  logic [WIDTH-1:0]       buf_data;
  logic                   buf_full;
  logic [WIDTH-1:0]       shift_reg;
  logic [WIDTH-1:0]       shift_nxt;
  logic [CW-1:0]          bit_cnt;
  state_t                 state;

  logic                   sdo_q;
  logic                   ready_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   underrun_q;
  logic                   aborted_q;

  logic                   accept;
  logic                   start;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync  <= '1;
      sck_sync <= '0;
      cs_hist  <= 1'b1;
      sck_hist <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.spi_sck};
      cs_hist  <= cs_sync[SYNC_STAGES-1];
      sck_hist <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_fall  = cs_hist & ~cs_s;
  assign cs_rise  = ~cs_hist & cs_s;
  assign sck_rise = ~sck_hist & sck_s;
  assign sck_fall = sck_hist & ~sck_s;

  // The CS synchronizer resets to "inactive", so a CS held low through reset
  // would look like a fresh fall. Arm only once the pipeline has flushed and
  // CS is genuinely seen high.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= FLUSH_LOAD;
      cs_armed  <= 1'b0;
    end else if (flush_cnt != '0) begin
      flush_cnt <= flush_cnt - FW'(1);
    end else if (cs_s) begin
      cs_armed <= 1'b1;
    end
  end

  assign accept    = bus.tx_valid & ready_q;
  assign start     = cs_fall & cs_armed;
  assign shift_nxt = {shift_reg[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      buf_data   <= '0;
      buf_full   <= 1'b0;
      ready_q    <= 1'b1;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      sdo_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      aborted_q  <= 1'b0;

      // Acceptance and a start that finds the buffer empty may coincide; the
      // new word then waits for the following transfer.
      if (accept) begin
        buf_data <= bus.tx_data;
        buf_full <= 1'b1;
        ready_q  <= 1'b0;
      end

      case (state)
        IDLE: begin
          sdo_q  <= 1'b0;
          busy_q <= 1'b0;
          if (start) begin
            state   <= SHIFT;
            busy_q  <= 1'b1;
            bit_cnt <= '0;
            if (buf_full) begin
              shift_reg <= buf_data;
              sdo_q     <= buf_data[WIDTH-1];
              buf_full  <= 1'b0;
              ready_q   <= 1'b1;
            end else begin
              shift_reg  <= '0;
              underrun_q <= 1'b1;
            end
          end
        end

        SHIFT: begin
          busy_q <= 1'b1;
          sdo_q  <= shift_reg[WIDTH-1];
          if (cs_rise) begin
            state     <= IDLE;
            sdo_q     <= 1'b0;
            busy_q    <= 1'b0;
            aborted_q <= (bit_cnt != CNT_MAX);
          end else if (sck_rise) begin
            if (bit_cnt != CNT_MAX) begin
              bit_cnt <= bit_cnt + CW'(1);
              done_q  <= (bit_cnt == CNT_LAST);
            end
          end else if (sck_fall) begin
            shift_reg <= shift_nxt;
            sdo_q     <= shift_nxt[WIDTH-1];
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.spi_sdo  = sdo_q;
  assign bus.tx_ready = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.underrun = underrun_q;
  assign bus.aborted  = aborted_q;

endmodule

// File: tb/tb_mfp_spi_slave_responder.sv
// Bench for mfp_spi_slave_responder: a behavioural SPI master captures MISO and
// results are compared with a one-entry buffer model.
module tb_mfp_spi_slave_responder;

  localparam int W     = 16;
  localparam int S     = 2;
  localparam int HALF  = 25;
  localparam int SETUP = 10;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  mfp_spi_slave_responder_if #(.WIDTH(W)) bus ();

  mfp_spi_slave_responder #(.WIDTH(W), .SYNC_STAGES(S)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  int n_done   = 0;
  int n_under  = 0;
  int n_abort  = 0;

  always @(negedge clk) begin
    if (bus.done)     n_done++;
    if (bus.underrun) n_under++;
    if (bus.aborted)  n_abort++;
  end

  typedef struct {
    bit         do_write;
    logic [W-1:0] word;
    int         nbits;
    logic [W-1:0] exp_cap;
    bit         exp_done;
    bit         exp_under;
    bit         exp_abort;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_word(input logic [W-1:0] w);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.tx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("write_ready", bus.tx_ready, 1);
    bus.tx_data  = w;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    chk("ready_drop", bus.tx_ready, 0);
  endtask

  // Full master transaction; coll drives a write in the cycle the synchronized
  // CS fall reaches the slave.
  task automatic run_xfer(input string name, input int nbits, input bit coll,
                          input logic [W-1:0] coll_word, input logic [W-1:0] exp_cap,
                          input bit exp_done, input bit exp_under, input bit exp_abort,
                          input bit exp_ready_mid);
    logic [W-1:0] cap;
    int s_done, s_under, s_abort;
    cap     = '0;
    s_done  = n_done;
    s_under = n_under;
    s_abort = n_abort;
    @(negedge clk);
    bus.spi_cs_n = 1'b0;
    if (coll) begin
      repeat (S) @(negedge clk);
      bus.tx_data  = coll_word;
      bus.tx_valid = 1'b1;
      @(negedge clk);
      bus.tx_valid = 1'b0;
    end
    wait_clks(SETUP);
    chk({name, "_ready_mid"}, bus.tx_ready, exp_ready_mid);
    chk({name, "_busy_mid"}, bus.busy, 1);
    for (int i = 0; i < nbits; i++) begin
      cap = {cap[W-2:0], bus.spi_sdo};
      bus.spi_sck = 1'b1;
      wait_clks(HALF);
      bus.spi_sck = 1'b0;
      wait_clks(HALF);
    end
    bus.spi_cs_n = 1'b1;
    wait_clks(HALF);
    chk({name, "_cap"}, cap, exp_cap);
    chk({name, "_done"}, n_done - s_done, exp_done);
    chk({name, "_underrun"}, n_under - s_under, exp_under);
    chk({name, "_aborted"}, n_abort - s_abort, exp_abort);
    chk({name, "_sdo_after"}, bus.spi_sdo, 0);
    chk({name, "_busy_after"}, bus.busy, 0);
  endtask

  initial begin
    logic [W-1:0] w;
    logic [W-1:0] word;
    logic [W-1:0] ecap;
    bit   model_full;
    logic [W-1:0] model_word;
    int   nbits;
    int   hi_cnt;
    int   s_under, s_done;

    vecs[0] = '{1'b1, 16'h1FE0, 16, 16'h1FE0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'h0000, 16, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 16'hA5C3,  5, 16'h0014, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 16'h0000, 16, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 16'h5A0F, 16, 16'h5A0F, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 16'h8000,  1, 16'h0001, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 16'h0000,  0, 16'h0000, 1'b0, 1'b1, 1'b1};

    bus.spi_cs_n = 1'b1;
    bus.spi_sck  = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    rst = 1'b1;
    wait_clks(4);
    rst = 1'b0;
    wait_clks(10);

    chk("rst_sdo", bus.spi_sdo, 0);
    chk("rst_ready", bus.tx_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_underrun", bus.underrun, 0);
    chk("rst_aborted", bus.aborted, 0);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].do_write) write_word(vecs[i].word);
      run_xfer($sformatf("vec%0d", i), vecs[i].nbits, 1'b0, '0, vecs[i].exp_cap,
               vecs[i].exp_done, vecs[i].exp_under, vecs[i].exp_abort, 1'b1);
      chk($sformatf("vec%0d_ready_end", i), bus.tx_ready, 1);
    end

    // Back-pressure: second word must wait for the first to be consumed.
    write_word(16'h0001);
    bus.tx_data  = 16'hFFFF;
    bus.tx_valid = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.tx_ready) hi_cnt++;
    end
    chk("bp_ready_held", hi_cnt, 0);
    run_xfer("bp_first", 16, 1'b0, '0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.tx_valid = 1'b0;
    chk("bp_ready_between", bus.tx_ready, 0);
    run_xfer("bp_second", 16, 1'b0, '0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);

    // Write coinciding with the synchronized CS fall.
    run_xfer("coll_first", 16, 1'b1, 16'h8001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    run_xfer("coll_second", 16, 1'b0, '0, 16'h8001, 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a transfer with CS held low.
    write_word(16'hC3A5);
    @(negedge clk);
    bus.spi_cs_n = 1'b0;
    wait_clks(SETUP);
    for (int i = 0; i < 4; i++) begin
      bus.spi_sck = 1'b1;
      wait_clks(HALF);
      bus.spi_sck = 1'b0;
      wait_clks(HALF);
    end
    rst = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    wait_clks(2);
    chk("rstmid_sdo", bus.spi_sdo, 0);
    chk("rstmid_busy", bus.busy, 0);
    chk("rstmid_ready", bus.tx_ready, 1);
    s_under = n_under;
    s_done  = n_done;
    write_word(16'hBEEF);
    hi_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      bus.spi_sck = 1'b1;
      wait_clks(HALF);
      if (bus.busy) hi_cnt++;
      bus.spi_sck = 1'b0;
      wait_clks(HALF);
      if (bus.busy) hi_cnt++;
    end
    chk("rstmid_no_start", hi_cnt, 0);
    chk("rstmid_buf_kept", bus.tx_ready, 0);
    chk("rstmid_no_underrun", n_under - s_under, 0);
    chk("rstmid_no_done", n_done - s_done, 0);
    bus.spi_cs_n = 1'b1;
    wait_clks(HALF);
    run_xfer("rstmid_next", 16, 1'b0, '0, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b1);

    // Randomized transfers against a one-entry buffer model.
    model_full = 1'b0;
    model_word = '0;
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 2) != 0 && !model_full) begin
        w = W'($urandom);
        write_word(w);
        model_full = 1'b1;
        model_word = w;
      end
      chk($sformatf("rnd%0d_ready_pre", it), bus.tx_ready, !model_full);
      nbits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : W;
      word  = model_full ? model_word : '0;
      ecap  = (nbits == 0) ? '0 : (word >> (W - nbits));
      run_xfer($sformatf("rnd%0d", it), nbits, 1'b0, '0, ecap,
               nbits == W, !model_full, nbits < W, 1'b1);
      model_full = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
